// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared encodings, cause codes and FSM state type for the writeback stage
package writeback_pkg;

    // rd write-back source select
    localparam logic [1:0] WS_ALU     = 2'd0;
    localparam logic [1:0] WS_LOAD    = 2'd1;
    localparam logic [1:0] WS_CSR     = 2'd2;
    localparam logic [1:0] WS_NEXT_PC = 2'd3;

    // synchronous exception cause codes (mcause, interrupt bit clear)
    localparam logic [3:0] CAUSE_FETCH_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_t;

    // rd value mux shared by the stage and anything that wants to predict it
    function automatic logic [31:0] select_rd_data(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] load,
        input logic [31:0] csr,
        input logic [31:0] npc
    );
        logic [31:0] result;
        unique case (sel)
            WS_ALU:     result = alu;
            WS_LOAD:    result = load;
            WS_CSR:     result = csr;
            default:    result = npc;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/writeback_counters.sv
// rtl/writeback_counters.sv - 64-bit cycle and retired-instruction counters (used with WRITEBACK_COUNTERS_EN)
module writeback_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        retired,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
);

    // free-running cycle counter and retire counter, both wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= 64'd0;
            instret_count <= 64'd0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
            if (retired) begin
                instret_count <= instret_count + 64'd1;
            end
        end
    end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - retire stage: rd/CSR write ports, trap/mret/wfi redirect; optional counters via WRITEBACK_COUNTERS_EN
module writeback
    import writeback_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] load_data_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        interrupt_pending,
    input  logic        interrupt_enable,
    input  logic [3:0]  interrupt_cause,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        reg_write,
    output logic [4:0]  reg_address,
    output logic [31:0] reg_data,
    output logic        csr_write,
    output logic [11:0] csr_address,
    output logic [31:0] csr_data,
    output logic        trap,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_pc,
    output logic        mret_taken,
    output logic        redirect,
    output logic [31:0] redirect_address,
    output logic        flush,
    output logic        stall_request,
    output logic        retired
`ifdef WRITEBACK_COUNTERS_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
`endif
);

    wb_state_t   state;
    wb_state_t   next_state;
    logic [31:0] wake_pc;
    logic        wfi_enter;
    logic [31:0] mtvec_base;

    assign mtvec_base = {mtvec[31:2], 2'b00};

    // retire / trap resolution; everything here is zero-latency from the inputs and state
    always_comb begin
        reg_write        = 1'b0;
        reg_address      = 5'd0;
        reg_data         = 32'd0;
        csr_write        = 1'b0;
        csr_address      = 12'd0;
        csr_data         = 32'd0;
        trap             = 1'b0;
        trap_cause       = 32'd0;
        trap_pc          = 32'd0;
        mret_taken       = 1'b0;
        redirect         = 1'b0;
        redirect_address = 32'd0;
        flush            = 1'b0;
        stall_request    = 1'b0;
        retired          = 1'b0;
        next_state       = state;
        wfi_enter        = 1'b0;

        if (reset) begin
            redirect_address = RESET_VECTOR;
            next_state       = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (valid_in) begin
                        if (exception_in) begin
                            trap             = 1'b1;
                            trap_cause       = {28'd0, ecause_in};
                            trap_pc          = pc_in;
                            redirect         = 1'b1;
                            redirect_address = mtvec_base;
                            flush            = 1'b1;
                        end else if (interrupt_pending && interrupt_enable) begin
                            // interrupt is taken in front of this instruction, which does not retire
                            trap             = 1'b1;
                            trap_cause       = {1'b1, 27'd0, interrupt_cause};
                            trap_pc          = pc_in;
                            redirect         = 1'b1;
                            redirect_address = mtvec_base;
                            flush            = 1'b1;
                        end else begin
                            retired     = 1'b1;
                            reg_write   = (rd_address_in != 5'd0);
                            reg_address = rd_address_in;
                            reg_data    = select_rd_data(write_select_in, alu_data_in,
                                                         load_data_in, csr_data_in, next_pc_in);
                            csr_write   = csr_write_in;
                            csr_address = csr_address_in;
                            csr_data    = alu_data_in;
                            if (mret_in) begin
                                mret_taken       = 1'b1;
                                redirect         = 1'b1;
                                redirect_address = mepc;
                                flush            = 1'b1;
                            end else if (wfi_in) begin
                                flush      = 1'b1;
                                next_state = ST_WAIT;
                                wfi_enter  = 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    stall_request = 1'b1;
                    if (interrupt_pending) begin
                        next_state = ST_RUN;
                        flush      = 1'b1;
                        redirect   = 1'b1;
                        if (interrupt_enable) begin
                            trap             = 1'b1;
                            trap_cause       = {1'b1, 27'd0, interrupt_cause};
                            trap_pc          = wake_pc;
                            redirect_address = mtvec_base;
                        end else begin
                            redirect_address = wake_pc;
                        end
                    end
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
        end
    end

    // run/wait state and the resume address captured when a wfi retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            wake_pc <= 32'd0;
        end else begin
            state <= next_state;
            if (wfi_enter) begin
                wake_pc <= next_pc_in;
            end
        end
    end

`ifdef WRITEBACK_COUNTERS_EN
    writeback_counters u_counters (
        .clk           (clk),
        .reset         (reset),
        .retired       (retired),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );
`endif

endmodule
